// File: rtl/tetris_pkg.sv
// Shared Tetris definitions.
// Contents:
//   game_state_e - game FSM state codes (PRE, DRO, DEL, END), also used by the game FSM
//   cmd_e        - board datapath command codes (NONE..GRAV)
//   arb_state_e  - move scheduler arbiter states
//   pend_t       - pending move request flags
//   pick_cmd     - fixed-priority selection GRAV > DOWN > ROT > LEFT > RIGHT
package tetris_pkg;

  typedef enum logic [1:0] {
    StPre = 2'd0,
    StDro = 2'd1,
    StDel = 2'd2,
    StEnd = 2'd3
  } game_state_e;

  typedef enum logic [2:0] {
    CmdNone  = 3'd0,
    CmdLeft  = 3'd1,
    CmdRight = 3'd2,
    CmdRot   = 3'd3,
    CmdDown  = 3'd4,
    CmdGrav  = 3'd5
  } cmd_e;

  typedef enum logic {
    ArbIdle = 1'b0,
    ArbBusy = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic grav;
    logic down;
    logic rot;
    logic left;
    logic right;
  } pend_t;

  function automatic cmd_e pick_cmd(input pend_t p);
    cmd_e c;
    if (p.grav)       c = CmdGrav;
    else if (p.down)  c = CmdDown;
    else if (p.rot)   c = CmdRot;
    else if (p.left)  c = CmdLeft;
    else if (p.right) c = CmdRight;
    else              c = CmdNone;
    return c;
  endfunction

endpackage

// File: rtl/move_sched_if.sv
// Command handshake between the move scheduler and the board datapath.
// Signals:
//   cmd_valid - command offered (driven by master)
//   cmd       - command code, stable while cmd_valid is high (driven by master)
//   cmd_ack   - datapath consumed the command (driven by slave)
interface move_sched_if;
  import tetris_pkg::*;

  logic cmd_valid;
  cmd_e cmd;
  logic cmd_ack;

  modport master (
    output cmd_valid,
    output cmd,
    input  cmd_ack
  );

  modport slave (
    input  cmd_valid,
    input  cmd,
    output cmd_ack
  );

endinterface

// File: rtl/grav_timer.sv
// Level-dependent gravity timer.
// Ports:
//   clk, rst - clock and synchronous active-high reset
//   en       - counting enable (game in DRO); counter held at 0 when low
//   clr      - soft drop issued: restart the period, suppressing any coincident wrap
//   level    - current level, period re-evaluated every cycle
//   tick     - wrap pulse, one cycle, combinational from the counter state
module grav_timer #(
  parameter int unsigned TICK_W      = 26,
  parameter int unsigned BASE_PERIOD = 25_000_000,
  parameter int unsigned STEP        = 2_000_000,
  parameter int unsigned MIN_PERIOD  = 2_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  input  logic [3:0] level,
  output logic       tick
);

  localparam int unsigned PW = TICK_W + 4;
  localparam logic [PW-1:0] Span = PW'(BASE_PERIOD - MIN_PERIOD);

  logic [TICK_W-1:0] r_gcnt;
  logic [PW-1:0]     w_prod;
  logic [PW-1:0]     w_period;
  logic              w_wrap;

  always_comb begin
    w_prod = PW'(level) * PW'(STEP);
    // Clamp before subtracting so high levels never underflow.
    if (w_prod >= Span) w_period = PW'(MIN_PERIOD);
    else                w_period = PW'(BASE_PERIOD) - w_prod;
    // >= rather than == so a level jump past the current count wraps at once.
    w_wrap = PW'(r_gcnt) >= (w_period - PW'(1));
    tick   = en & ~clr & w_wrap;
  end

  always_ff @(posedge clk) begin
    if (rst || !en || clr) r_gcnt <= '0;
    else if (w_wrap)       r_gcnt <= '0;
    else                   r_gcnt <= r_gcnt + TICK_W'(1);
  end

endmodule

// File: rtl/move_sched.sv
// Move scheduler: merges player move pulses and gravity ticks into one command
// stream towards the board datapath, one command in flight at a time.
// Ports:
//   clk, rst          - clock and synchronous active-high reset
//   state             - game FSM state; the scheduler only runs in DRO
//   level             - current level, sets the gravity period
//   btn_left/right/rot/down - single-cycle request pulses
//   bus               - command handshake (master side: cmd_valid, cmd out; cmd_ack in)
module move_sched
  import tetris_pkg::*;
#(
  parameter int unsigned TICK_W      = 26,
  parameter int unsigned BASE_PERIOD = 25_000_000,
  parameter int unsigned STEP        = 2_000_000,
  parameter int unsigned MIN_PERIOD  = 2_500_000
) (
  input  logic          clk,
  input  logic          rst,
  input  game_state_e   state,
  input  logic [3:0]    level,
  input  logic          btn_left,
  input  logic          btn_right,
  input  logic          btn_rot,
  input  logic          btn_down,
  move_sched_if.master  bus
);

  logic       w_dro;
  logic       w_tick;
  logic       w_down_issued;
  pend_t      r_pend, w_pend_nxt, w_set, w_clr;
  arb_state_e r_state, w_state_nxt;
  logic       r_cmd_valid, w_cmd_valid_nxt;
  cmd_e       r_cmd, w_cmd_nxt, w_issue;

  assign w_dro         = (state == StDro);
  assign w_down_issued = (w_issue == CmdDown);

  grav_timer #(
    .TICK_W      (TICK_W),
    .BASE_PERIOD (BASE_PERIOD),
    .STEP        (STEP),
    .MIN_PERIOD  (MIN_PERIOD)
  ) u_grav_timer (
    .clk   (clk),
    .rst   (rst),
    .en    (w_dro),
    .clr   (w_down_issued),
    .level (level),
    .tick  (w_tick)
  );

  // Arbiter / handshake FSM. Leaving DRO aborts unconditionally, ack included.
  always_comb begin
    w_state_nxt     = r_state;
    w_cmd_valid_nxt = r_cmd_valid;
    w_cmd_nxt       = r_cmd;
    w_issue         = CmdNone;
    if (!w_dro) begin
      w_state_nxt     = ArbIdle;
      w_cmd_valid_nxt = 1'b0;
      w_cmd_nxt       = CmdNone;
    end else begin
      unique case (r_state)
        ArbIdle: begin
          w_issue = pick_cmd(r_pend);
          if (w_issue != CmdNone) begin
            w_cmd_valid_nxt = 1'b1;
            w_cmd_nxt       = w_issue;
            w_state_nxt     = ArbBusy;
          end
        end
        ArbBusy: begin
          if (bus.cmd_ack) begin
            w_cmd_valid_nxt = 1'b0;
            w_cmd_nxt       = CmdNone;
            w_state_nxt     = ArbIdle;
          end
        end
        default: w_state_nxt = ArbIdle;
      endcase
    end
  end

  // Pending flags. Clearing on issue wins over a coincident pulse: that pulse
  // merges into the command being issued.
  always_comb begin
    w_set.grav  = w_tick;
    w_set.down  = btn_down;
    w_set.rot   = btn_rot;
    w_set.left  = btn_left;
    w_set.right = btn_right;
    w_clr.grav  = (w_issue == CmdGrav);
    w_clr.down  = (w_issue == CmdDown);
    w_clr.rot   = (w_issue == CmdRot);
    w_clr.left  = (w_issue == CmdLeft);
    w_clr.right = (w_issue == CmdRight);
    w_pend_nxt  = w_dro ? ((r_pend | w_set) & ~w_clr) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ArbIdle;
      r_cmd_valid <= 1'b0;
      r_cmd       <= CmdNone;
      r_pend      <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cmd_valid <= w_cmd_valid_nxt;
      r_cmd       <= w_cmd_nxt;
      r_pend      <= w_pend_nxt;
    end
  end

  assign bus.cmd_valid = r_cmd_valid;
  assign bus.cmd       = r_cmd;

endmodule
